// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state type, default timing constants and counter width
// for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 100000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int LOST_CNT_W        = 8;

  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// rtl/pll_sup_sync2.sv - two-flop synchronizer with asynchronous active-low reset.
module pll_sup_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer with registered resets and lock-loss count.
// Define PLL_LOCK_SUPERVISOR_FAULT_LATCH_EN to latch a FAIL state after MAX_RETRIES lock timeouts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  soft_reset_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic                  fault
);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           retry_q, retry_d;
  logic [LOST_CNT_W-1:0] lost_d;
  logic                  lk;
  logic                  retry_limit;

  pll_sup_sync2 u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lk)
  );

  assign retry_limit = (retry_q + 32'd1) >= 32'(MAX_RETRIES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lock_lost_cnt;
    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == 32'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_limit) begin
`ifdef PLL_LOCK_SUPERVISOR_FAULT_LATCH_EN
            state_d = ST_FAIL;
`else
            // Without the fault latch the retry count just saturates and retries go on.
            state_d = ST_PLL_RESET;
`endif
          end else begin
            state_d = ST_PLL_RESET;
            retry_d = retry_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == 32'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        retry_d = '0;
        if (!lk) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
          lost_d  = sat_inc(lock_lost_cnt);
        end
      end
      ST_FAIL: begin
`ifndef PLL_LOCK_SUPERVISOR_FAULT_LATCH_EN
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase
    // A soft request overrides the sequence but never counts as a lock loss itself.
    if (soft_reset_req) begin
      state_d = ST_PLL_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RESET;
      cnt_q         <= '0;
      retry_q       <= '0;
      lock_lost_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lock_lost_cnt <= lost_d;
      pll_rst       <= (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
      sys_rst_n     <= (state_d == ST_RUN);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_FAULT_LATCH_EN
  logic fault_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == ST_FAIL);
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
// (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [7:0] lock_lost_cnt;
  logic       fault;

  int n_tests;
  int n_fail;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .locked         (locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .lock_lost_cnt  (lock_lost_cnt),
    .fault          (fault)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    locked         = 1'b1;
    soft_reset_req = 1'b0;

    // Reset values while rst_n is low
    tick(2);
    chk("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("rst_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
    chk("rst_lost_cnt", lock_lost_cnt, 8'd0);
    chk("rst_fault", {7'd0, fault}, 8'd0);

    // Power-up: 4-cycle pll_rst pulse, then 1 WAIT_LOCK + 8 STABLE cycles to RUN
    rst_n = 1'b1;
    tick(1);
    chk("pwr_pll_rst_e1", {7'd0, pll_rst}, 8'd1);
    tick(2);
    chk("pwr_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("pwr_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
    tick(8);
    chk("pwr_sys_rst_e12", {7'd0, sys_rst_n}, 8'd0);
    tick(1);
    chk("pwr_sys_rst_e13", {7'd0, sys_rst_n}, 8'd1);
    chk("pwr_pll_rst_e13", {7'd0, pll_rst}, 8'd0);

    // Lock drop in RUN for 3 cycles
    locked = 1'b0;
    tick(2);
    chk("drop_sys_rst_2", {7'd0, sys_rst_n}, 8'd1);
    tick(1);
    chk("drop_sys_rst_3", {7'd0, sys_rst_n}, 8'd0);
    chk("drop_pll_rst_3", {7'd0, pll_rst}, 8'd1);
    chk("drop_lost_cnt", lock_lost_cnt, 8'd1);
    locked = 1'b1;
    tick(3);
    chk("drop_pll_rst_6", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("drop_pll_rst_7", {7'd0, pll_rst}, 8'd0);
    tick(8);
    chk("drop_sys_rst_15", {7'd0, sys_rst_n}, 8'd0);
    tick(1);
    chk("drop_sys_rst_16", {7'd0, sys_rst_n}, 8'd1);

    // Soft reset from RUN, then a one-cycle lock glitch at STABLE cycle 5
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    chk("soft_sys_rst", {7'd0, sys_rst_n}, 8'd0);
    chk("soft_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("soft_lost_cnt", lock_lost_cnt, 8'd1);
    tick(4);
    chk("soft_pll_rst_4", {7'd0, pll_rst}, 8'd0);
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(3);
    chk("glitch_sys_rst_early", {7'd0, sys_rst_n}, 8'd0);
    tick(7);
    chk("glitch_sys_rst_pre", {7'd0, sys_rst_n}, 8'd0);
    tick(1);
    chk("glitch_sys_rst_run", {7'd0, sys_rst_n}, 8'd1);

    // Simultaneous soft reset and lock loss in RUN: one increment, one pulse
    locked = 1'b0;
    tick(2);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    locked = 1'b1;
    chk("both_lost_cnt", lock_lost_cnt, 8'd2);
    chk("both_pll_rst", {7'd0, pll_rst}, 8'd1);
    tick(4);
    chk("both_pll_rst_4", {7'd0, pll_rst}, 8'd0);
    tick(9);
    chk("both_sys_rst_run", {7'd0, sys_rst_n}, 8'd1);

    // 260 further lock losses: the count saturates at 255
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      if (i == 0)   chk("sat_cnt_first", lock_lost_cnt, 8'd3);
      if (i == 251) chk("sat_cnt_254", lock_lost_cnt, 8'd254);
      if (i == 252) chk("sat_cnt_255", lock_lost_cnt, 8'd255);
      tick(13);
    end
    chk("sat_cnt_final", lock_lost_cnt, 8'd255);
    chk("sat_sys_rst_run", {7'd0, sys_rst_n}, 8'd1);

    // Soft reset in RUN leaves the count alone; then async reset while in STABLE
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    chk("soft2_lost_cnt", lock_lost_cnt, 8'd255);
    chk("soft2_sys_rst", {7'd0, sys_rst_n}, 8'd0);
    tick(7);
    chk("stable_pll_rst", {7'd0, pll_rst}, 8'd0);
    chk("stable_sys_rst", {7'd0, sys_rst_n}, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("async_sys_rst", {7'd0, sys_rst_n}, 8'd0);
    chk("async_lost_cnt", lock_lost_cnt, 8'd0);
    chk("async_fault", {7'd0, fault}, 8'd0);

    // No lock at all: 4-cycle pulse + 20-cycle wait per retry
    locked = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("to_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
    tick(19);
    chk("to_pll_rst_e23", {7'd0, pll_rst}, 8'd0);
    tick(1);
    chk("to_pll_rst_e24", {7'd0, pll_rst}, 8'd1);
    chk("to_fault_e24", {7'd0, fault}, 8'd0);
    tick(4);
    chk("to_pll_rst_e28", {7'd0, pll_rst}, 8'd0);
    tick(19);
    chk("to_pll_rst_e47", {7'd0, pll_rst}, 8'd0);
    tick(1);
    chk("to_pll_rst_e48", {7'd0, pll_rst}, 8'd1);
`ifdef PLL_LOCK_SUPERVISOR_FAULT_LATCH_EN
    chk("fail_fault_e48", {7'd0, fault}, 8'd1);
    tick(4);
    chk("fail_pll_rst_e52", {7'd0, pll_rst}, 8'd1);
    chk("fail_fault_e52", {7'd0, fault}, 8'd1);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    chk("fail_clear_fault", {7'd0, fault}, 8'd0);
    chk("fail_clear_pll_rst", {7'd0, pll_rst}, 8'd1);
`else
    chk("retry_fault_e48", {7'd0, fault}, 8'd0);
    tick(4);
    chk("retry_pll_rst_e52", {7'd0, pll_rst}, 8'd0);
    tick(20);
    chk("retry_pll_rst_e72", {7'd0, pll_rst}, 8'd1);
    chk("retry_fault_e72", {7'd0, fault}, 8'd0);
`endif
    chk("final_sys_rst", {7'd0, sys_rst_n}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
